// File: rtl/klotski_pkg.sv
// Shared definitions for the Klotski tile colour blocks: tile palette and paint FSM states.
// The RGB sort block imports the same PALETTE so both directions stay consistent.
package klotski_pkg;

    localparam int COLOR_W = 24;
    localparam int N_TILES = 16;
    localparam int IDX_W   = 4;

    localparam logic [COLOR_W-1:0] PALETTE [N_TILES] = '{
        24'hff7fff, 24'hffffff, 24'hffff00, 24'hff7f00,
        24'hff007f, 24'hff0000, 24'h7fff7f, 24'h7f7f00,
        24'h7f00ff, 24'h7f0000, 24'h00ffff, 24'h00ff00,
        24'h007fff, 24'h007f00, 24'h0000ff, 24'h000000
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tile_palette_rom.sv
// Combinational lookup from a 4-bit tile index to its 24-bit RGB colour.
module tile_palette_rom
    import klotski_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    output logic [COLOR_W-1:0] color
);

    assign color = PALETTE[idx];

endmodule

// File: rtl/rgb_order_painter.sv
// Paints the 16 board blocks from a tile order word, one block per cycle,
// and flags order words that are not a permutation of 0..15.
module rgb_order_painter
    import klotski_pkg::*;
#(
    parameter int CHECK_PERM = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [63:0]   i_order,
    output logic [23:0]   o_block0,
    output logic [23:0]   o_block1,
    output logic [23:0]   o_block2,
    output logic [23:0]   o_block3,
    output logic [23:0]   o_block4,
    output logic [23:0]   o_block5,
    output logic [23:0]   o_block6,
    output logic [23:0]   o_block7,
    output logic [23:0]   o_block8,
    output logic [23:0]   o_block9,
    output logic [23:0]   o_block10,
    output logic [23:0]   o_block11,
    output logic [23:0]   o_block12,
    output logic [23:0]   o_block13,
    output logic [23:0]   o_block14,
    output logic [23:0]   o_block15,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_error,
    output state_t        o_state
);

    state_t               state;
    state_t               state_next;
    logic [63:0]          order_q;
    logic [IDX_W-1:0]     cnt;
    logic [N_TILES-1:0]   seen;
    logic                 error_q;
    logic [IDX_W-1:0]     idx;
    logic [COLOR_W-1:0]   color;
    logic [COLOR_W-1:0]   blocks [N_TILES];

    assign idx = order_q[{cnt, 2'b00} +: IDX_W];

    tile_palette_rom u_rom (
        .idx   (idx),
        .color (color)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The 4-bit counter wraps 15->0 on the same edge that leaves RUN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = RUN;
            RUN:     if (cnt == 4'd15) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state != IDLE);
        o_done = (state == DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            order_q <= '0;
            cnt     <= '0;
            seen    <= '0;
            error_q <= 1'b0;
            for (int k = 0; k < N_TILES; k++) blocks[k] <= '0;
        end else begin
            if (state == IDLE && i_start) begin
                order_q <= i_order;
                cnt     <= '0;
                seen    <= '0;
                error_q <= 1'b0;
            end else if (state == RUN) begin
                blocks[cnt] <= color;
                if (CHECK_PERM != 0 && seen[idx]) error_q <= 1'b1;
                seen[idx] <= 1'b1;
                cnt       <= cnt + 4'd1;
            end
        end
    end

    assign o_error = (CHECK_PERM != 0) ? error_q : 1'b0;
    assign o_state = state;

    assign o_block0  = blocks[0];
    assign o_block1  = blocks[1];
    assign o_block2  = blocks[2];
    assign o_block3  = blocks[3];
    assign o_block4  = blocks[4];
    assign o_block5  = blocks[5];
    assign o_block6  = blocks[6];
    assign o_block7  = blocks[7];
    assign o_block8  = blocks[8];
    assign o_block9  = blocks[9];
    assign o_block10 = blocks[10];
    assign o_block11 = blocks[11];
    assign o_block12 = blocks[12];
    assign o_block13 = blocks[13];
    assign o_block14 = blocks[14];
    assign o_block15 = blocks[15];

endmodule

// File: doc/rgb_order_painter.md
Name: rgb_order_painter

Overview:
- Inverse of the RGB sort block: takes a 16-tile order word and produces the 24-bit RGB colour of each of the 16 board blocks from the fixed tile palette.
- Sits between the Klotski solver/move logic and the VGA overlay renderer, which draws the blocks.
- Paints sequentially, one block per cycle.
- Also checks that the order word is a true permutation of 0..15.

Parameters:
- CHECK_PERM, 1, when 1 duplicate indices raise o_error; when 0 o_error is tied low.
- COLOR_W, 24, width of one block colour; fixed at 24 for this design.

Ports:
- i_clk  in  1  system clock, 50 MHz domain.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  request to paint; sampled only in IDLE.
- i_order  in  64  nibble k (bits 4k+3:4k) is the tile index of block k.
- o_block0 .. o_block15  out  24 each  painted colour of block k.
- o_busy  out  1  high from the cycle after start acceptance until o_done falls.
- o_done  out  1  one-cycle completion pulse.
- o_error  out  1  duplicate index found; valid with o_done, held until the next accepted start.

Behaviour:
- Reset: while i_rst_n is low, asynchronously force:
  - all o_blockN = 24'h000000;
  - o_busy = 0, o_done = 0, o_error = 0;
  - state = IDLE, counter = 0, seen bitmap = 0.
- Reset mid-run aborts painting. No partial result is kept valid and o_done is not issued.
- Palette, index -> colour:
  - 0 ff7fff, 1 ffffff, 2 ffff00, 3 ff7f00
  - 4 ff007f, 5 ff0000, 6 7fff7f, 7 7f7f00
  - 8 7f00ff, 9 7f0000, 10 00ffff, 11 00ff00
  - 12 007fff, 13 007f00, 14 0000ff, 15 000000
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On a rising edge with i_start=1: latch i_order into an internal register, clear the seen bitmap, clear o_error, set cnt=0, go to RUN.
  - i_order changes after acceptance have no effect.
- RUN:
  - Each edge: idx = latched nibble cnt; o_block[cnt] <= palette[idx].
  - Seen/error update: if seen[idx] is already 1 and CHECK_PERM=1, set the error flag; then seen[idx] <= 1.
  - cnt increments. On the edge where cnt==15, go to DONE and register o_done=1.
  - Blocks not yet painted keep their previous colours.
- DONE:
  - o_done is high for exactly this one cycle.
  - Next edge: o_done <= 0, go to IDLE.
- Latency: if start is accepted at edge E0, o_done is high between E16 and E17.
- o_busy is high between E0 and E17.
- i_start is ignored in RUN and DONE (no queuing).
- Start held continuously high re-triggers at the first IDLE edge, so done pulses repeat every 18 cycles.
- Colours hold their final values until overwritten by a new run.
- o_error is asserted no later than the o_done cycle and stays high until the next accepted start.
- Counter is 4 bits; the wrap from 15 to 0 coincides with the RUN->DONE transition.

Decomposition:
- Shared package klotski_pkg:
  - COLOR_W, N_TILES=16, IDX_W=4;
  - 16-entry palette constant array;
  - state enum {IDLE, RUN, DONE}.
- The RGB sort block must import the same palette constant so both directions stay consistent.
- One sub-module: tile_palette_rom. It is a combinational lookup of a 4-bit index to a 24-bit colour, instantiated once and driven by the current nibble.

Test Plan:
- Identity order: i_order=64'hfedcba9876543210, start pulse.
  - o_done exactly 16 cycles after the accepting edge.
  - block0=ff7fff, block5=ff0000, block15=000000, o_error=0.
- Scrambled order: i_order=64'h95371fbd26480eac.
  - block0=007fff (12), block1=00ffff (10), block15=7f0000 (9), o_error=0.
- Duplicate order: i_order=64'h0 -> all blocks ff7fff, o_error=1 with o_done.
- Duplicate order, CHECK_PERM=0: same stimulus -> o_error=0.
- Busy start: start at E0, second start pulse at E5 with a different order.
  - Results reflect the first order only; exactly one o_done.
  - Held start gives the next o_done 18 cycles later.
- Reset mid-run: i_rst_n low at E8 of a run.
  - All blocks 000000, o_busy=0, no o_done.
  - A fresh start after release completes normally with correct colours.
